id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage that registers decoded operands and control, resolves data hazards, and drives the ALU's `ALU_control_E`, `rd1_E` and `srcB_E` inputs.

- Forwards results from the MEM and WB stages into the execute operands.
- Detects load-use hazards and inserts a bubble when one occurs.
- Supports external stall and flush.
- Sits between the register-file/decode stage and the ALU.

---
 rtl/id_ex_stage_pkg.sv | 35 +++
 rtl/id_ex_stage_forward_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and encodings for the decode-to-execute stage and its forwarding logic.
// Every file of the execute-stage slice imports this package.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 4;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1110
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Per-operand bypass select: newest in-flight producer (MEM) beats WB; x0 is never bypassed.
// Purely combinational, no backpressure.
module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = id_ex_stage_pkg::REG_W
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rd_M,
  input  logic [REG_W-1:0] i_rd_W,
  input  logic             i_reg_write_M,
  input  logic             i_reg_write_W,
  output logic [1:0]       o_sel
);

  logic w_hit_M;
  logic w_hit_W;

  assign w_hit_M = i_reg_write_M && (i_rd_M != '0) && (i_rd_M == i_rs);
  assign w_hit_W = i_reg_write_W && (i_rd_W != '0) && (i_rd_W == i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_M) begin
      o_sel = FWD_MEM;
    end else if (w_hit_W) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// D->E pipeline register with MEM/WB operand bypass and load-use bubble insertion.
// One cycle D to E; bypass muxes add no latency; lw_stall asks upstream to hold F/D.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_W  = id_ex_stage_pkg::REG_W,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_E,
  input  logic              flush_E,
  input  logic              valid_D,
  input  logic [DATA_W-1:0] rd1_D,
  input  logic [DATA_W-1:0] rd2_D,
  input  logic [DATA_W-1:0] imm_ext_D,
  input  logic [REG_W-1:0]  rs1_D,
  input  logic [REG_W-1:0]  rs2_D,
  input  logic [REG_W-1:0]  rd_D,
  input  logic [CTRL_W-1:0] ALU_control_D,
  input  logic              ALU_src_D,
  input  logic              reg_write_D,
  input  logic              mem_write_D,
  input  logic [1:0]        result_src_D,
  input  logic [DATA_W-1:0] ALU_result_M,
  input  logic [REG_W-1:0]  rd_M,
  input  logic              reg_write_M,
  input  logic [DATA_W-1:0] result_W,
  input  logic [REG_W-1:0]  rd_W,
  input  logic              reg_write_W,
  output logic [CTRL_W-1:0] ALU_control_E,
  output logic [DATA_W-1:0] rd1_E,
  output logic [DATA_W-1:0] srcB_E,
  output logic [DATA_W-1:0] write_data_E,
  output logic [REG_W-1:0]  rd_E,
  output logic              reg_write_E,
  output logic              mem_write_E,
  output logic [1:0]        result_src_E,
  output logic              valid_E,
  output logic [1:0]        forward_A_E,
  output logic [1:0]        forward_B_E,
  output logic              lw_stall
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
  } ex_reg_t;

  ex_reg_t           r_e;
  ex_reg_t           w_e_next;
  ex_reg_t           w_d_fields;
  logic              w_lw_stall;
  logic [1:0]        w_fwd_A;
  logic [1:0]        w_fwd_B;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;

  // The load in E must reach MEM before its data can be bypassed to a dependent op in D.
  assign w_lw_stall = r_e.valid
                   && (r_e.result_src == RES_LOAD)
                   && (r_e.rd != '0)
                   && ((r_e.rd == rs1_D) || (r_e.rd == rs2_D))
                   && valid_D;

  always_comb begin
    w_d_fields            = '0;
    w_d_fields.valid      = valid_D;
    w_d_fields.rd1        = rd1_D;
    w_d_fields.rd2        = rd2_D;
    w_d_fields.imm        = imm_ext_D;
    w_d_fields.rs1        = rs1_D;
    w_d_fields.rs2        = rs2_D;
    w_d_fields.rd         = rd_D;
    w_d_fields.alu_ctrl   = ALU_control_D;
    w_d_fields.alu_src    = ALU_src_D;
    w_d_fields.reg_write  = reg_write_D;
    w_d_fields.mem_write  = mem_write_D;
    w_d_fields.result_src = result_src_D;
  end

  // Flush outranks stall, stall outranks the load-use bubble.
  always_comb begin
    w_e_next = w_d_fields;
    if (flush_E) begin
      w_e_next = '0;
    end else if (stall_E) begin
      w_e_next = r_e;
    end else if (w_lw_stall) begin
      w_e_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e <= '0;
    end else begin
      r_e <= w_e_next;
    end
  end

  forward_unit #(.REG_W(REG_W)) u_fwd_A (
    .i_rs          (r_e.rs1),
    .i_rd_M        (rd_M),
    .i_rd_W        (rd_W),
    .i_reg_write_M (reg_write_M),
    .i_reg_write_W (reg_write_W),
    .o_sel         (w_fwd_A)
  );

  forward_unit #(.REG_W(REG_W)) u_fwd_B (
    .i_rs          (r_e.rs2),
    .i_rd_M        (rd_M),
    .i_rd_W        (rd_W),
    .i_reg_write_M (reg_write_M),
    .i_reg_write_W (reg_write_W),
    .o_sel         (w_fwd_B)
  );

  always_comb begin
    w_opA = r_e.rd1;
    case (w_fwd_A)
      FWD_MEM: w_opA = ALU_result_M;
      FWD_WB:  w_opA = result_W;
      default: w_opA = r_e.rd1;
    endcase
  end

  always_comb begin
    w_opB = r_e.rd2;
    case (w_fwd_B)
      FWD_MEM: w_opB = ALU_result_M;
      FWD_WB:  w_opB = result_W;
      default: w_opB = r_e.rd2;
    endcase
  end

  assign ALU_control_E = r_e.alu_ctrl;
  assign rd1_E         = w_opA;
  assign srcB_E        = r_e.alu_src ? r_e.imm : w_opB;
  assign write_data_E  = w_opB;
  assign rd_E          = r_e.rd;
  assign reg_write_E   = r_e.reg_write;
  assign mem_write_E   = r_e.mem_write;
  assign result_src_E  = r_e.result_src;
  assign valid_E       = r_e.valid;
  assign forward_A_E   = w_fwd_A;
  assign forward_B_E   = w_fwd_B;
  assign lw_stall      = w_lw_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios plus randomized traffic, checked against a cycle-level behavioural model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        stall_E;
  logic        flush_E;
  logic        valid_D;
  logic [31:0] rd1_D;
  logic [31:0] rd2_D;
  logic [31:0] imm_ext_D;
  logic [4:0]  rs1_D;
  logic [4:0]  rs2_D;
  logic [4:0]  rd_D;
  logic [3:0]  ALU_control_D;
  logic        ALU_src_D;
  logic        reg_write_D;
  logic        mem_write_D;
  logic [1:0]  result_src_D;
  logic [31:0] ALU_result_M;
  logic [4:0]  rd_M;
  logic        reg_write_M;
  logic [31:0] result_W;
  logic [4:0]  rd_W;
  logic        reg_write_W;
  logic [3:0]  ALU_control_E;
  logic [31:0] rd1_E;
  logic [31:0] srcB_E;
  logic [31:0] write_data_E;
  logic [4:0]  rd_E;
  logic        reg_write_E;
  logic        mem_write_E;
  logic [1:0]  result_src_E;
  logic        valid_E;
  logic [1:0]  forward_A_E;
  logic [1:0]  forward_B_E;
  logic        lw_stall;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_E(stall_E), .flush_E(flush_E), .valid_D(valid_D),
    .rd1_D(rd1_D), .rd2_D(rd2_D), .imm_ext_D(imm_ext_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .ALU_control_D(ALU_control_D), .ALU_src_D(ALU_src_D),
    .reg_write_D(reg_write_D), .mem_write_D(mem_write_D), .result_src_D(result_src_D),
    .ALU_result_M(ALU_result_M), .rd_M(rd_M), .reg_write_M(reg_write_M),
    .result_W(result_W), .rd_W(rd_W), .reg_write_W(reg_write_W),
    .ALU_control_E(ALU_control_E), .rd1_E(rd1_E), .srcB_E(srcB_E),
    .write_data_E(write_data_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
    .mem_write_E(mem_write_E), .result_src_E(result_src_E), .valid_E(valid_E),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E), .lw_stall(lw_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the instruction the E stage should be holding.
  logic        m_valid;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_ctrl;
  logic        m_src, m_rw, m_mw;
  logic [1:0]  m_res;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] ref_sel(input logic [4:0] rs);
    if (reg_write_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (reg_write_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_val(input logic [4:0] rs, input logic [31:0] held);
    logic [1:0] s;
    s = ref_sel(rs);
    if (s == 2'b10) return ALU_result_M;
    if (s == 2'b01) return result_W;
    return held;
  endfunction

  function automatic logic ref_lw();
    return m_valid && m_res == 2'b01 && m_rd != 0 && (m_rd == rs1_D || m_rd == rs2_D) && valid_D;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_ctrl = 0; m_src = 0; m_rw = 0; m_mw = 0; m_res = 0;
  endtask

  // Called at the rising edge, before inputs move; uses pre-edge model state.
  task automatic model_update();
    if (rst || flush_E || (!stall_E && ref_lw())) begin
      model_clear();
    end else if (!stall_E) begin
      m_valid = valid_D; m_rd1 = rd1_D; m_rd2 = rd2_D; m_imm = imm_ext_D;
      m_rs1 = rs1_D; m_rs2 = rs2_D; m_rd = rd_D; m_ctrl = ALU_control_D;
      m_src = ALU_src_D; m_rw = reg_write_D; m_mw = mem_write_D; m_res = result_src_D;
    end
  endtask

  task automatic check_all();
    chk("ALU_control_E", ALU_control_E, m_ctrl);
    chk("rd1_E", rd1_E, ref_val(m_rs1, m_rd1));
    chk("srcB_E", srcB_E, m_src ? m_imm : ref_val(m_rs2, m_rd2));
    chk("write_data_E", write_data_E, ref_val(m_rs2, m_rd2));
    chk("rd_E", rd_E, m_rd);
    chk("reg_write_E", reg_write_E, m_rw);
    chk("mem_write_E", mem_write_E, m_mw);
    chk("result_src_E", result_src_E, m_res);
    chk("valid_E", valid_E, m_valid);
    chk("forward_A_E", forward_A_E, ref_sel(m_rs1));
    chk("forward_B_E", forward_B_E, ref_sel(m_rs2));
    chk("lw_stall", lw_stall, ref_lw());
  endtask

  task automatic idle_inputs();
    rst = 0; stall_E = 0; flush_E = 0; valid_D = 0;
    rd1_D = 0; rd2_D = 0; imm_ext_D = 0; rs1_D = 0; rs2_D = 0; rd_D = 0;
    ALU_control_D = 0; ALU_src_D = 0; reg_write_D = 0; mem_write_D = 0; result_src_D = 0;
    ALU_result_M = 0; rd_M = 0; reg_write_M = 0; result_W = 0; rd_W = 0; reg_write_W = 0;
  endtask

  task automatic set_d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [1:0] res);
    valid_D = 1; ALU_control_D = op; rd1_D = a; rd2_D = b;
    rs1_D = s1; rs2_D = s2; rd_D = d; result_src_D = res;
    reg_write_D = 1; mem_write_D = 0; ALU_src_D = 0; imm_ext_D = 32'h0;
  endtask

  // Inputs are set on the falling edge; check, then advance one rising edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_clear();
    rst = 1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    step();
    chk("reset_valid", valid_E, 0);
    chk("reset_fwdA", forward_A_E, 0);
    chk("reset_lw", lw_stall, 0);

    // Plain add passes through in one cycle.
    idle_inputs();
    set_d(4'b0001, 32'd5, 32'd7, 5'd1, 5'd2, 5'd9, 2'b00);
    step();
    chk("add_rd1", rd1_E, 32'd5);
    chk("add_srcB", srcB_E, 32'd7);
    chk("add_ctrl", ALU_control_E, 4'b0001);
    chk("add_valid", valid_E, 1);

    // MEM beats WB on x3; WB alone supplies x4.
    set_d(4'b0010, 32'hA, 32'hB, 5'd3, 5'd4, 5'd10, 2'b00);
    step();
    stall_E = 1; valid_D = 0;
    rd_M = 3; reg_write_M = 1; ALU_result_M = 32'h11;
    rd_W = 3; reg_write_W = 1; result_W = 32'h22;
    #1;
    chk("prio_rd1", rd1_E, 32'h11);
    chk("prio_fwdA", forward_A_E, 2'b10);
    rd_W = 4; result_W = 32'h33;
    #1;
    chk("wb_srcB", srcB_E, 32'h33);
    chk("wb_fwdB", forward_B_E, 2'b01);
    step();

    // x0 is never forwarded.
    idle_inputs();
    set_d(4'b0001, 32'h5A, 32'h1, 5'd0, 5'd1, 5'd2, 2'b00);
    step();
    rd_M = 0; reg_write_M = 1; ALU_result_M = 32'hFF;
    #1;
    chk("x0_rd1", rd1_E, 32'h5A);
    chk("x0_fwdA", forward_A_E, 2'b00);
    step();

    // Load-use: bubble, then the re-presented instruction enters.
    idle_inputs();
    set_d(4'b0001, 32'h0, 32'h0, 5'd1, 5'd2, 5'd6, 2'b01);
    step();
    set_d(4'b0001, 32'h100, 32'h200, 5'd1, 5'd6, 5'd7, 2'b00);
    #1;
    chk("lu_stall", lw_stall, 1);
    step();
    chk("lu_bubble_valid", valid_E, 0);
    chk("lu_bubble_ctrl", ALU_control_E, 4'b0000);
    chk("lu_released", lw_stall, 0);
    step();
    chk("lu_reload_valid", valid_E, 1);
    chk("lu_reload_rd1", rd1_E, 32'h100);

    // Stall holds; flush wins over stall.
    set_d(4'b0011, 32'h77, 32'h1, 5'd1, 5'd2, 5'd3, 2'b00);
    step();
    stall_E = 1;
    set_d(4'b0100, 32'h99, 32'h2, 5'd1, 5'd2, 5'd3, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", rd1_E, 32'h77);
    end
    flush_E = 1;
    step();
    chk("flush_valid", valid_E, 0);
    chk("flush_ctrl", ALU_control_E, 4'b0000);

    // Immediate selects srcB; store data still carries rs2.
    idle_inputs();
    set_d(4'b0001, 32'h1, 32'd9, 5'd1, 5'd5, 5'd2, 2'b00);
    ALU_src_D = 1; imm_ext_D = 32'hFFFF_FFF8;
    step();
    chk("imm_srcB", srcB_E, 32'hFFFF_FFF8);
    chk("imm_wdata", write_data_E, 32'd9);

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall_E = ($urandom_range(0, 5) == 0);
      flush_E = ($urandom_range(0, 9) == 0);
      valid_D = ($urandom_range(0, 4) != 0);
      rd1_D = $urandom; rd2_D = $urandom; imm_ext_D = $urandom;
      rs1_D = 5'($urandom_range(0, 7));
      rs2_D = 5'($urandom_range(0, 7));
      rd_D = 5'($urandom_range(0, 7));
      ALU_control_D = 4'($urandom_range(0, 14));
      ALU_src_D = 1'($urandom_range(0, 1));
      reg_write_D = 1'($urandom_range(0, 1));
      mem_write_D = 1'($urandom_range(0, 1));
      result_src_D = 2'($urandom_range(0, 2));
      ALU_result_M = $urandom; rd_M = 5'($urandom_range(0, 7));
      reg_write_M = 1'($urandom_range(0, 1));
      result_W = $urandom; rd_W = 5'($urandom_range(0, 7));
      reg_write_W = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
